ccr_irq_sequencer: RTL

- Multi-cycle sequencer for interrupt entry and return-from-interrupt (RTI) in the 8-bit core.
- Entry: saves PC and the CCR flags {V,C,N,Z} to a down-growing memory stack, fetches the interrupt vector, then redirects the PC.
- RTI: pops the flags and PC, drives the CCR restore port (restore_en / restore_value) and reloads the PC.
- Sits between the decoder, the CCR, the PC register and the data-memory port; stalls the core while active.

---
 rtl/ccr_irq_sequencer_pkg.sv | 29 ++
 rtl/ccr_stack_ptr.sv | 46 ++++
 rtl/ccr_irq_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccr_irq_sequencer_pkg.sv
// Shared types and constants for the interrupt entry / RTI sequencer and its stack pointer.
// Flag bit positions follow the CCR layout {V,C,N,Z}.
package ccr_irq_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_PC   = 3'd1,
    PUSH_FLG  = 3'd2,
    FETCH_VEC = 3'd3,
    POP_FLG   = 3'd4,
    POP_PC    = 3'd5,
    RESUME    = 3'd6
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  localparam logic [7:0] DEF_STACK_TOP    = 8'hFF;
  localparam logic [7:0] DEF_IRQ_VEC_ADDR = 8'h00;
  localparam logic [7:0] DEF_STACK_LIMIT  = 8'hF0;

  // Stack byte layout of the saved flags: low nibble {V,C,N,Z}, high nibble zero.
  function automatic logic [7:0] flags_to_byte(input logic [3:0] f);
    flags_to_byte = {4'b0000, f[FLG_V], f[FLG_C], f[FLG_N], f[FLG_Z]};
  endfunction

endpackage

// File: rtl/ccr_stack_ptr.sv
// Stack pointer: resets to STACK_TOP, -1 per completed push, +1 per completed pop (mod 256).
// With STACK_GUARD_EN it also reports where the next sp lands relative to the legal window.
module ccr_stack_ptr
  import ccr_irq_sequencer_pkg::*;
#(
  parameter logic [7:0] STACK_TOP = DEF_STACK_TOP
`ifdef STACK_GUARD_EN
  , parameter logic [7:0] STACK_LIMIT = DEF_STACK_LIMIT
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp,
  output logic [7:0] sp_next
`ifdef STACK_GUARD_EN
  , output logic     below_limit
  , output logic     at_top
`endif
);

  always_comb begin
    sp_next = sp;
    if (inc) begin
      sp_next = sp + 8'd1;
    end else if (dec) begin
      sp_next = sp - 8'd1;
    end
  end

`ifdef STACK_GUARD_EN
  // Compared against the value sp will hold in the state being entered.
  assign below_limit = (sp_next < STACK_LIMIT);
  assign at_top      = (sp_next == STACK_TOP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= STACK_TOP;
    end else begin
      sp <= sp_next;
    end
  end

endmodule

// File: rtl/ccr_irq_sequencer.sv
// Interrupt entry / RTI sequencer: pushes PC+flags, fetches the vector, pops on RTI; stalls the core while busy.
// All outputs registered; memory requests hold until mem_ready. Optional stack guard: STACK_GUARD_EN.
module ccr_irq_sequencer
  import ccr_irq_sequencer_pkg::*;
#(
  parameter logic [7:0] STACK_TOP    = DEF_STACK_TOP,
  parameter logic [7:0] IRQ_VEC_ADDR = DEF_IRQ_VEC_ADDR,
  parameter logic [7:0] STACK_LIMIT  = DEF_STACK_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_req,
  input  logic       rti_req,
  input  logic [7:0] pc_in,
  input  logic [3:0] flags_in,
  output logic       irq_ack,
  output logic       stall,
  output logic       in_isr,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       ccr_restore_en,
  output logic [3:0] ccr_restore_value,
  output logic       pc_load_en,
  output logic [7:0] pc_load_value,
  output logic [7:0] sp_out,
  output logic       stack_fault
);

  if (STACK_LIMIT > STACK_TOP) begin : g_bad_limit
    $error("ccr_irq_sequencer: STACK_LIMIT must not exceed STACK_TOP");
  end

  state_t     state, seq_state, state_nxt;
  logic       is_rti, is_rti_nxt;
  logic [7:0] pc_lat, pc_lat_nxt;
  logic [3:0] flg_lat, flg_lat_nxt;
  logic [7:0] vec_lat, vec_lat_nxt;
  logic       sp_inc, sp_dec;
  logic [7:0] sp, sp_nxt;
  logic       isr_seq, in_isr_nxt, ack_nxt, stall_nxt;
  logic       mem_req_nxt, mem_we_nxt;
  logic [7:0] mem_addr_nxt, mem_wdata_nxt;
  logic       pc_load_en_nxt, ccr_restore_en_nxt;
  logic [7:0] pc_load_value_nxt;
  logic [3:0] ccr_restore_value_nxt;

`ifdef STACK_GUARD_EN
  logic below_limit, at_top, fault_nxt;

  ccr_stack_ptr #(
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (sp_inc),
    .dec         (sp_dec),
    .sp          (sp),
    .sp_next     (sp_nxt),
    .below_limit (below_limit),
    .at_top      (at_top)
  );
`else
  ccr_stack_ptr #(
    .STACK_TOP (STACK_TOP)
  ) u_sp (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (sp_inc),
    .dec     (sp_dec),
    .sp      (sp),
    .sp_next (sp_nxt)
  );
`endif

  assign sp_out = sp;

  // Sequencing: state progression, sp steps and data latches; independent of sp_nxt.
  always_comb begin
    seq_state   = state;
    is_rti_nxt  = is_rti;
    pc_lat_nxt  = pc_lat;
    flg_lat_nxt = flg_lat;
    vec_lat_nxt = vec_lat;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    ack_nxt     = 1'b0;
    isr_seq     = in_isr;
    case (state)
      IDLE: begin
        if (rti_req && in_isr) begin
          seq_state  = POP_FLG;
          is_rti_nxt = 1'b1;
        end else if (irq_req && !in_isr) begin
          seq_state   = PUSH_PC;
          is_rti_nxt  = 1'b0;
          pc_lat_nxt  = pc_in;
          flg_lat_nxt = flags_in;
          ack_nxt     = 1'b1;
        end
      end
      PUSH_PC: begin
        if (mem_ready) begin
          sp_dec    = 1'b1;
          seq_state = PUSH_FLG;
        end
      end
      PUSH_FLG: begin
        if (mem_ready) begin
          sp_dec    = 1'b1;
          seq_state = FETCH_VEC;
        end
      end
      FETCH_VEC: begin
        if (mem_ready) begin
          vec_lat_nxt = mem_rdata;
          seq_state   = RESUME;
        end
      end
      POP_FLG: begin
        if (mem_ready) begin
          sp_inc      = 1'b1;
          flg_lat_nxt = mem_rdata[3:0];
          seq_state   = POP_PC;
        end
      end
      POP_PC: begin
        if (mem_ready) begin
          sp_inc     = 1'b1;
          pc_lat_nxt = mem_rdata;
          seq_state  = RESUME;
        end
      end
      RESUME: begin
        isr_seq   = !is_rti;
        seq_state = IDLE;
      end
      default: seq_state = IDLE;
    endcase
  end

  // Guard override and registered-output decode of the state being entered.
  always_comb begin
    state_nxt  = seq_state;
    in_isr_nxt = isr_seq;
`ifdef STACK_GUARD_EN
    fault_nxt = stack_fault;
    if ((state_nxt == PUSH_PC || state_nxt == PUSH_FLG) && below_limit) begin
      state_nxt = IDLE;
      fault_nxt = 1'b1;
    end
    if ((state_nxt == POP_FLG || state_nxt == POP_PC) && at_top) begin
      state_nxt  = IDLE;
      fault_nxt  = 1'b1;
      in_isr_nxt = 1'b0;
    end
`endif
    stall_nxt             = (state_nxt != IDLE);
    mem_req_nxt           = 1'b0;
    mem_we_nxt            = 1'b0;
    mem_addr_nxt          = 8'h00;
    mem_wdata_nxt         = 8'h00;
    pc_load_en_nxt        = 1'b0;
    pc_load_value_nxt     = 8'h00;
    ccr_restore_en_nxt    = 1'b0;
    ccr_restore_value_nxt = 4'h0;
    case (state_nxt)
      PUSH_PC: begin
        mem_req_nxt   = 1'b1;
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = sp_nxt;
        mem_wdata_nxt = pc_lat_nxt;
      end
      PUSH_FLG: begin
        mem_req_nxt   = 1'b1;
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = sp_nxt;
        mem_wdata_nxt = flags_to_byte(flg_lat_nxt);
      end
      FETCH_VEC: begin
        mem_req_nxt  = 1'b1;
        mem_addr_nxt = IRQ_VEC_ADDR;
      end
      POP_FLG, POP_PC: begin
        mem_req_nxt  = 1'b1;
        mem_addr_nxt = sp_nxt + 8'd1;
      end
      RESUME: begin
        pc_load_en_nxt    = 1'b1;
        pc_load_value_nxt = is_rti_nxt ? pc_lat_nxt : vec_lat_nxt;
        if (is_rti_nxt) begin
          ccr_restore_en_nxt    = 1'b1;
          ccr_restore_value_nxt = flg_lat_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rti            <= 1'b0;
      pc_lat            <= 8'h00;
      flg_lat           <= 4'h0;
      vec_lat           <= 8'h00;
      irq_ack           <= 1'b0;
      stall             <= 1'b0;
      in_isr            <= 1'b0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= 8'h00;
      mem_wdata         <= 8'h00;
      ccr_restore_en    <= 1'b0;
      ccr_restore_value <= 4'h0;
      pc_load_en        <= 1'b0;
      pc_load_value     <= 8'h00;
    end else begin
      is_rti            <= is_rti_nxt;
      pc_lat            <= pc_lat_nxt;
      flg_lat           <= flg_lat_nxt;
      vec_lat           <= vec_lat_nxt;
      irq_ack           <= ack_nxt;
      stall             <= stall_nxt;
      in_isr            <= in_isr_nxt;
      mem_req           <= mem_req_nxt;
      mem_we            <= mem_we_nxt;
      mem_addr          <= mem_addr_nxt;
      mem_wdata         <= mem_wdata_nxt;
      ccr_restore_en    <= ccr_restore_en_nxt;
      ccr_restore_value <= ccr_restore_value_nxt;
      pc_load_en        <= pc_load_en_nxt;
      pc_load_value     <= pc_load_value_nxt;
    end
  end

`ifdef STACK_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_fault <= 1'b0;
    end else begin
      stack_fault <= fault_nxt;
    end
  end
`else
  assign stack_fault = 1'b0;
`endif

endmodule
